accum_seq: RTL and testbench
============================

# accum_seq

Sequential accumulation stage wrapped around the 32-bit `fullAdder`. Accepts a stream of 32-bit two's-complement operands over a valid/ready handshake and feeds the adder with A = running accumulator and B = incoming operand. It registers the adder's `sum`/`cout` back into the accumulator and presents the final total with sticky carry and overflow flags on a second valid/ready handshake. The block is both the adder's operand source and the consumer of its result. It instantiates one `fullAdder` internally.

## Interface
- `CNT_W`, 8 — width of the operand-count input; max sequence length 2^CNT_W − 1.
- `clk  in  1` — single clock; all state updates on rising edge.
- `rst  in  1` — synchronous, active-high reset.
- `start  in  1` — begin a new sequence; sampled only in IDLE.
- `len  in  CNT_W` — number of operands in the sequence; sampled with `start`.
- `in_valid  in  1` — operand beat valid.
- `in_data  in  32` — operand, two's complement.
- `in_ready  out  1` — block accepts a beat this cycle.
- `out_valid  out  1` — result valid.
- `out_sum  out  32` — accumulated total.
- `out_carry  out  1` — sticky OR of adder `cout` over the sequence.
- `out_ovf  out  1` — sticky signed-overflow flag.
- `out_ready  in  1` — consumer accepts the result.
- `busy  out  1` — high in ACCUM or DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 with `len`≠0: acc←0, remaining←`len`, carry/ovf←0, go to ACCUM.
  - `start`=1 with `len`=0: acc←0, flags←0, go directly to DONE.
- **ACCUM**
  - `in_ready`=1.
  - A beat is accepted when `in_valid`&&`in_ready`. On each accepted beat:
    - acc←`sum`.
    - carry←carry | `cout`.
    - ovf←ovf | (A[31]==B[31] && `sum`[31]≠A[31]).
    - remaining←remaining−1.
  - If remaining==1 at acceptance, go to DONE.
  - Cycles without `in_valid` leave all state unchanged.
- **DONE**
  - `out_valid`=1; `out_sum`/`out_carry`/`out_ovf` are held stable.
  - On `out_ready`=1, go to IDLE.
- `start` is ignored outside IDLE.
- `len` is ignored except when sampled with `start` in IDLE.
- Arithmetic is modulo 2^32; the adder is combinational between acc and `in_data`.
- `out_sum` reflects the acc register directly; it is meaningful only while `out_valid`=1.

## Timing
- Reset values:
  - State = IDLE, acc = 0, remaining = 0.
  - `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_carry`=0, `out_ovf`=0, `busy`=0.
- `rst` overrides everything, including mid-sequence and while DONE is stalled. Any partial sum is discarded.
- The `start` cycle moves the FSM to ACCUM; `in_ready` rises the following cycle.
- One beat per cycle at full throughput; N operands take N accept cycles.
- `out_valid` rises the cycle after the last beat is accepted (latency 1).
- In DONE, `out_valid` stays high until the cycle `out_ready`=1. The FSM is back in IDLE the next cycle.
- A new `start` is accepted in IDLE at the earliest, i.e. one cycle after the result handshake. Minimum sequence period is N+2 cycles.
- `in_ready` is registered state (no combinational path from `out_ready` or `in_valid`).

## Configuration
- `ACCUM_SAT_EN`
  - **Defined:** on an accepted beat with signed overflow, acc←0x7FFFFFFF if A[31]=0, else 0x80000000. Accumulation continues from the clamped value. `out_ovf` is still set sticky.
  - **Undefined:** plain wrap-around; acc←`sum` unconditionally.

## Test plan
- len=2, beats 3 then 4, `out_ready`=1 → `out_valid` one cycle after the 2nd beat; `out_sum`=0x00000007, `out_carry`=0, `out_ovf`=0.
- len=2, beats 0xFFFFFFFB then 3 → `out_sum`=0xFFFFFFFE, `out_carry`=0, `out_ovf`=0.
- len=3, beats 0, 0xFFFFFFFE, 0xFFFFFFFD → `out_sum`=0xFFFFFFFB, `out_carry`=1, `out_ovf`=0.
- len=2, beats 0x7FFFFFFF then 1 → `out_ovf`=1, `out_carry`=0.
  - Without `ACCUM_SAT_EN`: `out_sum`=0x80000000.
  - With `ACCUM_SAT_EN`: `out_sum`=0x7FFFFFFF.
- Backpressure and bubbles: len=2 with an `in_valid` gap between beats 5 and 6; hold `out_ready`=0 for 4 cycles → `out_sum`=0x0000000B held stable with `out_valid`=1 for all 4 cycles; IDLE reached one cycle after `out_ready`=1.
- Corner/reset cases:
  - len=0 with `start` → DONE next cycle, `out_sum`=0.
  - `rst` asserted after 1 of 3 beats → all outputs 0 the next cycle.
  - A fresh len=1 sequence with beat 9 afterwards returns 9.

Source files
------------

// File: rtl/accum_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : accum_seq_if
// Description : Operand-in / result-out valid-ready bundle for accum_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface accum_seq_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_ovf;
    logic        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : accum_seq (with internal fullAdder)
// Description : Streams operands through a 32-bit adder into a running total,
//               reporting sticky carry / signed overflow. Define ACCUM_SAT_EN
//               to clamp the total on signed overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module fullAdder (
    input  wire logic [31:0] a,
    input  wire logic [31:0] b,
    input  wire logic        cin,
    output logic      [31:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module accum_seq #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [CNT_W-1:0] len,
    output logic                  busy,
    accum_seq_if.slave            bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [31:0]      acc, acc_next;
    logic [CNT_W-1:0] remaining, remaining_next;
    logic             carry, carry_next;
    logic             ovf, ovf_next;

    logic [31:0]      sum;
    logic             cout;
    logic             beat_ovf;
    logic [31:0]      beat_acc;

    fullAdder u_adder (
        .a    (acc),
        .b    (bus.in_data),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Signed overflow: operands agree in sign but the result does not.
    assign beat_ovf = (acc[31] == bus.in_data[31]) && (sum[31] != acc[31]);

`ifdef ACCUM_SAT_EN
    assign beat_acc = beat_ovf ? (acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum;
`else
    assign beat_acc = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 32'd0;
            remaining <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            remaining <= remaining_next;
            carry     <= carry_next;
            ovf       <= ovf_next;
        end
    end

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        remaining_next = remaining;
        carry_next     = carry;
        ovf_next       = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next       = 32'd0;
                    carry_next     = 1'b0;
                    ovf_next       = 1'b0;
                    remaining_next = len;
                    state_next     = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_next       = beat_acc;
                    carry_next     = carry | cout;
                    ovf_next       = ovf | beat_ovf;
                    remaining_next = remaining - 1'b1;
                    if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = acc;
    assign bus.out_carry = carry;
    assign bus.out_ovf   = ovf;
    assign busy          = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_seq
// Description : Self-checking bench for accum_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_seq;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             busy;

    accum_seq_if bus ();

    accum_seq #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .busy  (busy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] bq[$];
    logic [31:0] m_acc;
    logic        m_carry;
    logic        m_ovf;
    logic [31:0] last_sum;
    logic        last_carry;
    logic        last_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer arithmetic on the true mathematical sum.
    task automatic model_beat(input logic [31:0] d);
        logic [63:0] us;
        longint      ss;
        us = {32'd0, m_acc} + {32'd0, d};
        ss = longint'($signed(m_acc)) + longint'($signed(d));
        m_carry = m_carry | (us > 64'h0000_0000_FFFF_FFFF);
        if (ss > 64'sd2147483647 || ss < -64'sd2147483648) begin
            m_ovf = 1'b1;
`ifdef ACCUM_SAT_EN
            m_acc = (ss > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
            m_acc = us[31:0];
`endif
        end else begin
            m_acc = us[31:0];
        end
    endtask

    task automatic run_seq(input int n, input int gap_pct, input int stall, input string tag);
        m_acc = 32'd0; m_carry = 1'b0; m_ovf = 1'b0;
        start = 1'b1; len = n[CNT_W-1:0];
        step();
        start = 1'b0; len = CNT_W'($urandom);
        check({tag, "/busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
                bus.in_valid = 1'b0;
                start = 1'($urandom_range(1));
                len   = CNT_W'($urandom);
                step();
                start = 1'b0;
            end
            check({tag, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
            check({tag, "/early_valid"}, {31'd0, bus.out_valid}, 32'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = bq[i];
            step();
            model_beat(bq[i]);
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
        end
        check({tag, "/out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "/in_ready_done"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "/sum"}, bus.out_sum, m_acc);
        check({tag, "/carry"}, {31'd0, bus.out_carry}, {31'd0, m_carry});
        check({tag, "/ovf"}, {31'd0, bus.out_ovf}, {31'd0, m_ovf});
        last_sum = bus.out_sum; last_carry = bus.out_carry; last_ovf = bus.out_ovf;
        for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            start = 1'($urandom_range(1));
            step();
            start = 1'b0;
            check({tag, "/stall_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, "/stall_sum"}, bus.out_sum, m_acc);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "/idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "/idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0;
        bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check("reset/in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("reset/out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset/sum", bus.out_sum, 32'd0);
        check("reset/flags", {30'd0, bus.out_carry, bus.out_ovf}, 32'd0);
        check("reset/busy", {31'd0, busy}, 32'd0);
        step();

        bq = '{32'd3, 32'd4};
        run_seq(2, 0, 0, "add3_4");
        check("add3_4/const", last_sum, 32'h0000_0007);

        bq = '{32'hFFFF_FFFB, 32'd3};
        run_seq(2, 0, 0, "neg");
        check("neg/const", last_sum, 32'hFFFF_FFFE);

        bq = '{32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        run_seq(3, 0, 0, "carry");
        check("carry/const", {last_sum[31:1], last_carry}, {32'hFFFF_FFFB >> 1, 1'b1});

        bq = '{32'h7FFF_FFFF, 32'd1};
        run_seq(2, 0, 0, "ovf");
        check("ovf/flag", {30'd0, last_ovf, last_carry}, 32'd2);
`ifdef ACCUM_SAT_EN
        check("ovf/const", last_sum, 32'h7FFF_FFFF);
`else
        check("ovf/const", last_sum, 32'h8000_0000);
`endif

        bq = '{32'd5, 32'd6};
        run_seq(2, 100, 4, "bp");
        check("bp/const", last_sum, 32'h0000_000B);

        run_seq(0, 0, 1, "len0");
        check("len0/const", last_sum, 32'd0);

        // Reset mid-sequence discards the partial total.
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'd77;
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst/in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("midrst/out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst/sum", bus.out_sum, 32'd0);
        check("midrst/busy", {31'd0, busy}, 32'd0);

        bq = '{32'd9};
        run_seq(1, 0, 0, "one");
        check("one/const", last_sum, 32'd9);

        for (int t = 0; t < 25; t++) begin
            int n;
            n = int'($urandom_range(1, 6));
            bq.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(3))
                    0:       bq.push_back(32'h7FFF_FFFF - $urandom_range(3));
                    1:       bq.push_back(32'h8000_0000 + $urandom_range(3));
                    default: bq.push_back($urandom);
                endcase
            end
            run_seq(n, 30, int'($urandom_range(2)), $sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
